// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear controller for four cascaded BCD digits (MM:SS).
// Divides clk into a count tick and steps the digits up or down.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned MAX_MIN  = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        mode,
  input  logic        preset_load,
  input  logic [15:0] preset,
  output logic [15:0] digits,
  output logic [3:0]  digit_en,
  output logic        up_down,
  output logic        tick,
  output logic        running,
  output logic        done
);

  localparam int unsigned DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  // Up-mode terminal digits double as down-mode wrap targets.
  localparam logic [15:0] WRAP = 16'h9959;
  localparam logic [15:0] TOP = {
    4'(MAX_MIN / 10), 4'(MAX_MIN % 10), 4'd5, 4'd9
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   digits_q, digits_d;
  logic [15:0]   stepped, clamped;
  logic [DW-1:0] div_q, div_d;
  logic          dir_q, dir_d;
  logic [3:0]    at_term;
  logic [3:0]    en;

  function automatic logic [3:0] clamp(
    input logic [3:0] d,
    input logic [3:0] hi
  );
    return (d > hi) ? hi : d;
  endfunction

  // Tick, carry-chain enables, stepped digits and clamped preset.
  always_comb begin
    tick    = (state_q == RUN) && (div_q == DIV_LAST);
    at_term = '0;
    stepped = digits_q;
    for (int i = 0; i < 4; i++) begin
      at_term[i] = digits_q[4*i +: 4] ==
                   (dir_q ? WRAP[4*i +: 4] : 4'd0);
    end
    en[0] = tick;
    en[1] = tick & at_term[0];
    en[2] = tick & (&at_term[1:0]);
    en[3] = tick & (&at_term[2:0]);
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        if (dir_q)
          stepped[4*i +: 4] = at_term[i] ? 4'd0
                              : digits_q[4*i +: 4] + 4'd1;
        else
          stepped[4*i +: 4] = at_term[i] ? WRAP[4*i +: 4]
                              : digits_q[4*i +: 4] - 4'd1;
      end
    end
    clamped = {
      clamp(preset[15:12], 4'd9),
      clamp(preset[11:8],  4'd9),
      clamp(preset[7:4],   4'd5),
      clamp(preset[3:0],   4'd9)
    };
  end

  // Next-state logic; clear wins over every other pulse.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    div_d    = div_q;
    dir_d    = dir_q;
    unique case (state_q)
      IDLE: begin
        if (preset_load) digits_d = clamped;
        if (start_stop) begin
          dir_d = ~mode;
          div_d = '0;
          state_d = (mode && digits_q == 16'h0)
                    ? DONE : RUN;
        end
      end
      RUN: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (start_stop) state_d = PAUSE;
        if (tick) begin
          if (dir_q && digits_q == TOP) begin
            state_d = DONE;
          end else begin
            digits_d = stepped;
            if (!dir_q && digits_q == 16'h0001)
              state_d = DONE;
          end
        end
      end
      PAUSE: begin
        if (preset_load) digits_d = clamped;
        if (start_stop)
          state_d = (!dir_q && digits_q == 16'h0)
                    ? DONE : RUN;
      end
      DONE: begin
        if (preset_load) begin
          digits_d = clamped;
          state_d  = PAUSE;
        end
      end
    endcase
    if (clear) begin
      state_d  = IDLE;
      digits_d = '0;
      div_d    = '0;
    end
  end

  // State, digit, divider and direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      div_q    <= '0;
      dir_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      div_q    <= div_d;
      dir_q    <= dir_d;
    end
  end

  assign digits   = digits_q;
  assign digit_en = en;
  assign up_down  = dir_q;
  assign running  = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule
